i2c_frame_master: RTL and testbench
===================================

// Module: i2c_frame_master
// PURPOSE
//  Bit-level I2C master for the audio-codec configuration path. Accepts one
//  3-byte write frame (device addr+W, reg byte hi, reg byte lo) per start
//  request, serialises it on SCL/SDA with START/STOP and checks each ACK.
//  Sits directly downstream of the codec initializer: the initializer issues
//  frames and waits on o_done; this block owns all pin timing.
// PARAMETERS
//  CLK_DIV   250  i_clk cycles per SCL quarter-period (>=1); 250 @ 100 MHz = 100 kHz SCL
//  N_BYTES   3    bytes per frame, MSB byte first
// PORTS
//  i_clk      in   1            system clock
//  i_rst      in   1            synchronous reset, active-high
//  i_start    in   1            frame request; accepted only when o_busy=0
//  i_frame    in   8*N_BYTES    frame data, latched on acceptance, MSB sent first
//  o_busy     out  1            high from acceptance until o_done cycle inclusive
//  o_done     out  1            1-cycle pulse after STOP completes
//  o_ack_err  out  1            set with o_done if any NACK; cleared on next accept
//  o_sclk     out  1            SCL level
//  o_sdat     out  1            SDA value when driven
//  o_oen      out  1            1 = drive SDA; 0 = release (ACK slot only)
//  i_sdat     in   1            sampled SDA pin
// BEHAVIOUR
//  Clock/reset: one clock, reset synchronous active-high on i_rst.
//  Reset values: o_sclk=1 o_sdat=1 o_oen=1 o_busy=0 o_done=0 o_ack_err=0; FSM->IDLE,
//   tick counter=0. Reset mid-frame aborts immediately, no STOP emitted.
//  Tick: quarter strobe every CLK_DIV cycles, counter runs only when busy.
//  Every symbol = 4 quarters q0..q3. FSM: IDLE->START->DATA->ACK->(DATA|STOP)->DONE->IDLE.
//   IDLE : sclk=1 sdat=1 oen=1. i_start & !o_busy -> latch frame, busy=1, clear ack_err.
//   START: q0 sclk=1 sdat=1; q1 sdat=0; q2,q3 sclk=0.
//   DATA : q0 sclk=0, sdat=next bit; q1,q2 sclk=1; q3 sclk=0. 8 bits per byte.
//   ACK  : oen=0 for all 4 quarters; sclk as DATA; sample i_sdat at end of q2.
//          0 -> ACK: next byte or STOP after byte N_BYTES-1. 1 -> NACK: ack_err=1, go STOP.
//   STOP : q0 sclk=0 sdat=0 oen=1; q1,q2 sclk=1 sdat=0; q3 sdat=1.
//   DONE : o_done=1 one cycle, o_busy=1 that cycle, then IDLE.
//  Latency: accept -> o_done = (2 + 9*N_BYTES)*4*CLK_DIV cycles on full ACK path.
//  i_start while busy: ignored, not queued. i_start in DONE cycle: ignored.
//  i_frame changes after acceptance: no effect.
//  Byte/bit counters wrap to 0 at each byte/frame boundary; no overflow state.
// CONFIGURATION
//  I2C_NACK_RETRY_EN defined: on NACK, emit STOP then restart the same latched
//   frame up to 3 retries total; o_ack_err set only if the final attempt NACKs;
//   o_busy stays high throughout, o_done pulses once at the very end.
//  Undefined: first NACK -> STOP -> DONE with o_ack_err=1, no retry.
// STRUCTURE
//  Package i2c_pkg: state enum (IDLE,START,DATA,ACK,STOP,DONE), 2-bit quarter
//   typedef, WM8731_ADDR_W = 8'h34, MAX_RETRY = 3.
//  Sub-module i2c_tick_gen: CLK_DIV counter, enable input, 1-cycle quarter strobe.
// TESTING (CLK_DIV=2, N_BYTES=3, slave model drives ACK)
//  1 Reset: i_rst=1 2 cycles mid-DATA -> next cycle sclk=1 sdat=1 oen=1 busy=0.
//  2 Frame 24'h34_1E_00, all ACK -> bits on SCL rise match MSB-first,
//    o_done at 232 cycles after accept, o_ack_err=0.
//  3 Slave NACKs byte 2 -> STOP after 2nd ACK slot, o_done with o_ack_err=1.
//  4 i_start pulsed at cycles 10 and 231 of a frame -> ignored, one o_done only.
//  5 START/STOP check: SDA falls while SCL=1 at start, rises while SCL=1 at stop;
//    SDA never changes while SCL=1 elsewhere; oen=0 only in ACK slots.
//  6 I2C_NACK_RETRY_EN, NACK first 2 tries -> 3 frames on bus, o_ack_err=0, one o_done.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C frame master.
// Symbol pin levels are decoded here so the FSM can register them directly.
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, ACK, STOP, DONE} state_t;

  typedef logic [1:0] quarter_t;

  localparam logic [7:0]  WM8731_ADDR_W = 8'h34;
  localparam int unsigned MAX_RETRY     = 3;

  typedef struct packed {
    logic sclk;
    logic sdat;
    logic oen;
  } pins_t;

  // Pin levels for one quarter of a symbol; bit_val is the data bit on the wire.
  function automatic pins_t pins_for(state_t st, quarter_t q, logic bit_val);
    pins_t p;
    p.sclk = 1'b1;
    p.sdat = 1'b1;
    p.oen  = 1'b1;
    case (st)
      START: begin
        p.sclk = (q < 2'd2);
        p.sdat = (q == 2'd0);
      end
      DATA: begin
        p.sclk = (q == 2'd1) || (q == 2'd2);
        p.sdat = bit_val;
      end
      ACK: begin
        p.sclk = (q == 2'd1) || (q == 2'd2);
        p.oen  = 1'b0;
      end
      STOP: begin
        p.sclk = (q != 2'd0);
        p.sdat = (q == 2'd3);
      end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/i2c_frame_master_tick.sv
// Quarter-period strobe for the I2C master: one-cycle pulse every CLK_DIV
// enabled cycles; the count restarts from zero whenever disabled.
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          last;

  assign last   = (cnt == CW'(CLK_DIV - 1));
  assign o_tick = i_en && last;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_frame_master.sv
// Bit-level I2C write master: START, N_BYTES bytes with ACK checks, STOP.
// Define I2C_NACK_RETRY_EN to restart the latched frame after a NACK (MAX_RETRY times).
module i2c_frame_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250,
  parameter int unsigned N_BYTES = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [8*N_BYTES-1:0] i_frame,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_ack_err,
  output logic                 o_sclk,
  output logic                 o_sdat,
  output logic                 o_oen,
  input  logic                 i_sdat
);

  localparam int unsigned    FW        = 8 * N_BYTES;
  localparam int unsigned    BW        = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [BW-1:0]  LAST_BYTE = BW'(N_BYTES - 1);

  state_t        state, state_n;
  quarter_t      q, q_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [BW-1:0] byte_cnt, byte_n;
  logic [FW-1:0] sr, sr_n;
  logic          nack, nack_n;
  logic          err, err_n;
  logic          busy_n, done_n, ack_err_n;
  pins_t         pins_n;
  logic          tick_en, tick;

`ifdef I2C_NACK_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_cnt, retry_n;
  logic          retry_pend, pend_n;
  logic [FW-1:0] frame_lat, lat_n;
`endif

  assign tick_en = o_busy && !o_done;

  i2c_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (tick_en),
    .o_tick(tick)
  );

  always_comb begin
    state_n   = state;
    q_n       = q;
    bit_n     = bit_cnt;
    byte_n    = byte_cnt;
    sr_n      = sr;
    nack_n    = nack;
    err_n     = err;
    busy_n    = o_busy;
    done_n    = 1'b0;
    ack_err_n = o_ack_err;
`ifdef I2C_NACK_RETRY_EN
    retry_n   = retry_cnt;
    pend_n    = retry_pend;
    lat_n     = frame_lat;
`endif
    case (state)
      IDLE: begin
        if (i_start && !o_busy) begin
          state_n   = START;
          q_n       = '0;
          bit_n     = '0;
          byte_n    = '0;
          sr_n      = i_frame;
          err_n     = 1'b0;
          ack_err_n = 1'b0;
          busy_n    = 1'b1;
`ifdef I2C_NACK_RETRY_EN
          retry_n   = '0;
          pend_n    = 1'b0;
          lat_n     = i_frame;
`endif
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        if (tick) begin
          q_n = q + 2'd1;
          case (state)
            START: if (q == 2'd3) state_n = DATA;
            DATA: begin
              if (q == 2'd3) begin
                sr_n  = {sr[FW-2:0], 1'b0};
                bit_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = ACK;
              end
            end
            ACK: begin
              if (q == 2'd2) nack_n = i_sdat;
              if (q == 2'd3) begin
                if (nack) begin
                  state_n = STOP;
                  byte_n  = '0;
`ifdef I2C_NACK_RETRY_EN
                  if (retry_cnt < RW'(MAX_RETRY)) begin
                    pend_n  = 1'b1;
                    retry_n = retry_cnt + RW'(1);
                  end else begin
                    err_n = 1'b1;
                  end
`else
                  err_n = 1'b1;
`endif
                end else if (byte_cnt == LAST_BYTE) begin
                  state_n = STOP;
                  byte_n  = '0;
                end else begin
                  state_n = DATA;
                  byte_n  = byte_cnt + BW'(1);
                end
              end
            end
            STOP: begin
              if (q == 2'd3) begin
`ifdef I2C_NACK_RETRY_EN
                if (retry_pend) begin
                  state_n = START;
                  sr_n    = frame_lat;
                  pend_n  = 1'b0;
                end else begin
                  state_n   = DONE;
                  done_n    = 1'b1;
                  ack_err_n = err;
                end
`else
                state_n   = DONE;
                done_n    = 1'b1;
                ack_err_n = err;
`endif
              end
            end
            default: ;
          endcase
        end
      end
    endcase
    // Pins are decoded from the next state so they change on the same edge as it.
    pins_n = pins_for(state_n, q_n, sr_n[FW-1]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      q         <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      sr        <= '0;
      nack      <= 1'b0;
      err       <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_ack_err <= 1'b0;
      o_sclk    <= 1'b1;
      o_sdat    <= 1'b1;
      o_oen     <= 1'b1;
`ifdef I2C_NACK_RETRY_EN
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
      frame_lat  <= '0;
`endif
    end else begin
      state     <= state_n;
      q         <= q_n;
      bit_cnt   <= bit_n;
      byte_cnt  <= byte_n;
      sr        <= sr_n;
      nack      <= nack_n;
      err       <= err_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
      o_ack_err <= ack_err_n;
      o_sclk    <= pins_n.sclk;
      o_sdat    <= pins_n.sdat;
      o_oen     <= pins_n.oen;
`ifdef I2C_NACK_RETRY_EN
      retry_cnt  <= retry_n;
      retry_pend <= pend_n;
      frame_lat  <= lat_n;
`endif
    end
  end

endmodule

// File: tb/tb_i2c_frame_master.sv
// Bench for i2c_frame_master: bus decoder + ACK/NACK slave, checked against
// a byte-level model of what each frame should put on the wire.
module tb_i2c_frame_master;
  import i2c_pkg::*;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned N_BYTES = 3;
  localparam int unsigned FW      = 8 * N_BYTES;
  localparam int          QCYC    = 4 * CLK_DIV;
`ifdef I2C_NACK_RETRY_EN
  localparam int MAX_ATT = 1 + int'(MAX_RETRY);
`else
  localparam int MAX_ATT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [FW-1:0] frame = '0;
  logic          busy, done, ack_err, sclk, sdat, oen, sdat_in;

  always #5 clk = ~clk;

  i2c_frame_master #(
    .CLK_DIV(CLK_DIV),
    .N_BYTES(N_BYTES)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_frame  (frame),
    .o_busy   (busy),
    .o_done   (done),
    .o_ack_err(ack_err),
    .o_sclk   (sclk),
    .o_sdat   (sdat),
    .o_oen    (oen),
    .i_sdat   (sdat_in)
  );

  int tests = 0;
  int fails = 0;

  // Byte index each attempt NACKs, or -1 for a fully ACKed attempt.
  int nack_plan [4] = '{-1, -1, -1, -1};

  logic         mon_clr = 1'b0;
  logic         prev_scl, prev_sda, pend, rise_sda, rise_oen;
  int           mon_starts, mon_stops, mon_idx, mon_acks, mon_nbits;
  int           mon_oen_bad, mon_unstable, mon_oen_low, mon_dones;
  logic [127:0] mon_bits;
  logic         sda_line, sl_nack;

  assign sda_line = oen ? sdat : sdat_in;

  always_comb begin
    sl_nack = 1'b0;
    if (mon_starts >= 1 && mon_starts <= 4)
      sl_nack = (nack_plan[mon_starts-1] == mon_idx / 9);
  end
  assign sdat_in = oen ? 1'b1 : sl_nack;

  always @(negedge clk) begin
    if (rst || mon_clr) begin
      prev_scl     <= sclk;
      prev_sda     <= sda_line;
      pend         <= 1'b0;
      rise_sda     <= 1'b0;
      rise_oen     <= 1'b1;
      mon_starts   <= 0;
      mon_stops    <= 0;
      mon_idx      <= 0;
      mon_acks     <= 0;
      mon_nbits    <= 0;
      mon_oen_bad  <= 0;
      mon_unstable <= 0;
      mon_oen_low  <= 0;
      mon_dones    <= 0;
      mon_bits     <= '0;
    end else begin
      prev_scl <= sclk;
      prev_sda <= sda_line;
      if (!oen) mon_oen_low <= mon_oen_low + 1;
      if (done) mon_dones <= mon_dones + 1;
      if (prev_scl && sclk && prev_sda && !sda_line) begin
        mon_starts <= mon_starts + 1;
        mon_idx    <= 0;
        pend       <= 1'b0;
      end else if (prev_scl && sclk && !prev_sda && sda_line) begin
        mon_stops <= mon_stops + 1;
        pend      <= 1'b0;
      end else if (!prev_scl && sclk) begin
        pend     <= 1'b1;
        rise_sda <= sda_line;
        rise_oen <= oen;
      end else if (prev_scl && !sclk && pend) begin
        pend <= 1'b0;
        if (sda_line !== rise_sda) mon_unstable <= mon_unstable + 1;
        if (mon_idx % 9 == 8) begin
          mon_acks <= mon_acks + 1;
          if (rise_oen) mon_oen_bad <= mon_oen_bad + 1;
        end else begin
          if (!rise_oen) mon_oen_bad <= mon_oen_bad + 1;
          mon_bits  <= {mon_bits[126:0], rise_sda};
          mon_nbits <= mon_nbits + 1;
        end
        mon_idx <= mon_idx + 1;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected wire traffic: every attempt sends bytes up to and including the
  // NACKed one; a further attempt follows only while retries remain.
  task automatic model(input logic [FW-1:0] f, output logic [127:0] bits, output int nbits,
                       output int attempts, output int bytes_total, output int cycles,
                       output logic err);
    bits = '0; nbits = 0; attempts = 0; bytes_total = 0; cycles = 0; err = 1'b0;
    for (int a = 0; a < MAX_ATT; a++) begin
      int sent;
      attempts++;
      sent = (nack_plan[a] >= 0) ? nack_plan[a] + 1 : int'(N_BYTES);
      for (int b = 0; b < sent; b++)
        for (int k = 7; k >= 0; k--) begin
          bits = {bits[126:0], f[8*(int'(N_BYTES)-1-b)+k]};
          nbits++;
        end
      bytes_total += sent;
      cycles      += (2 + 9 * sent) * QCYC;
      err          = (nack_plan[a] >= 0);
      if (!err) break;
    end
  endtask

  task automatic run_frame(input string name, input logic [FW-1:0] f, input bit poke);
    logic [127:0] eb;
    int           en, ea, ebt, ecyc, n, busy_low;
    logic         eerr;
    bit           seen;
    model(f, eb, en, ea, ebt, ecyc, eerr);
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    frame = f;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({name, ":busy_on_accept"}, int'(busy), 1);
    seen = 1'b0;
    busy_low = 0;
    n = 0;
    for (int c = 1; c <= 4000; c++) begin
      @(posedge clk);
      #1;
      if (poke && (c == 10 || c == 231)) begin
        start = 1'b1;
        frame = FW'($urandom);
      end else begin
        start = 1'b0;
      end
      if (!busy) busy_low++;
      if (done) begin
        seen = 1'b1;
        n = c;
        break;
      end
    end
    chk({name, ":done_seen"}, int'(seen), 1);
    chk({name, ":latency"}, n, ecyc);
    chk({name, ":ack_err"}, int'(ack_err), int'(eerr));
    chk({name, ":busy_held"}, busy_low, 0);
    if (poke) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({name, ":busy_after_done"}, int'(busy), 0);
    repeat (20) @(posedge clk);
    #1;
    chk({name, ":done_pulses"}, mon_dones, 1);
    chk({name, ":starts"}, mon_starts, ea);
    chk({name, ":stops"}, mon_stops, ea);
    chk({name, ":ack_slots"}, mon_acks, ebt);
    chk({name, ":nbits"}, mon_nbits, en);
    chk_v({name, ":bits"}, mon_bits, eb);
    chk({name, ":sda_unstable"}, mon_unstable, 0);
    chk({name, ":oen_slot"}, mon_oen_bad, 0);
    chk({name, ":oen_low_cycles"}, mon_oen_low, ebt * QCYC);
    chk({name, ":idle_pins"}, int'({sclk, sdat, oen}), 7);
  endtask

  task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
    nack_plan[0] = p0;
    nack_plan[1] = p1;
    nack_plan[2] = p2;
    nack_plan[3] = p3;
  endtask

  initial begin
    int v [4];
    repeat (3) @(posedge clk);
    #1;
    chk("reset:pins", int'({sclk, sdat, oen}), 7);
    chk("reset:busy_done_err", int'({busy, done, ack_err}), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    set_plan(-1, -1, -1, -1);
    run_frame("codec_frame", {WM8731_ADDR_W, 16'h1E00}, 1'b0);

    // Abort mid-DATA: reset for two cycles, pins return to idle with no STOP.
    frame = FW'($urandom);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("midreset:pins", int'({sclk, sdat, oen}), 7);
    chk("midreset:busy_done_err", int'({busy, done, ack_err}), 0);
    repeat (300) @(posedge clk);
    #1;
    chk("midreset:no_done", mon_dones, 0);
    chk("midreset:no_bus_activity", mon_starts + mon_stops, 0);

    set_plan(1, -1, -1, -1);
    run_frame("nack_byte2", FW'($urandom), 1'b0);

    set_plan(-1, -1, -1, -1);
    run_frame("start_while_busy", FW'($urandom), 1'b1);

    set_plan(0, 2, -1, -1);
    run_frame("nack_twice", FW'($urandom), 1'b0);

    set_plan(2, 2, 2, 2);
    run_frame("nack_always", FW'($urandom), 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        v[i] = int'($urandom_range(0, 4));
        if (v[i] >= int'(N_BYTES)) v[i] = -1;
      end
      set_plan(v[0], v[1], v[2], v[3]);
      run_frame($sformatf("random%0d", r), FW'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
